// File: rtl/rv32i_if_fetch.sv
// RV32I instruction-fetch stage: fetch PC, in-order imem handshake, small {pc, word} FIFO, redirect/flush.
// Optional RV32I_IF_MISALIGN_CHK_EN: misaligned redirect target sets a sticky flag and halts fetching.
module rv32i_if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jump_en_in,
    input  logic [31:0] jump_addr_in,
    input  logic        stall_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] iw_out,
    output logic [31:0] pc_out,
    output logic        jump_en_out,
    output logic        fetch_misalign_out
);
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    logic [31:0]   r_fpc;
    logic [31:0]   r_rpc;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [31:0]   r_mem_pc [FIFO_DEPTH];
    logic [31:0]   r_mem_iw [FIFO_DEPTH];

    logic          w_halted;
    logic          w_req;
    logic          w_grant;
    logic          w_drop_rsp;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_jump_tgt;
    logic [CW-1:0] w_credit;

    assign w_jump_tgt = {jump_addr_in[31:2], 2'b00};
    // Credits cover both in-flight requests and buffered words, so a push can never overflow.
    assign w_credit   = CW'(r_out + r_count);
    assign w_req      = reset && !w_halted && !jump_en_in && (w_credit < DEPTH_C);
    assign w_grant    = w_req && imem_gnt;
    assign w_drop_rsp = imem_rvalid && (r_drop != '0);
    assign w_push     = imem_rvalid && (r_drop == '0) && !jump_en_in;
    assign w_pop      = !jump_en_in && !stall_in && (r_count != '0);

    assign imem_req   = w_req;
    assign imem_addr  = r_fpc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fpc   <= RESET_PC;
            r_rpc   <= RESET_PC;
            r_out   <= '0;
            r_drop  <= '0;
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            r_out <= r_out + CW'(w_grant) - CW'(imem_rvalid);
            if (jump_en_in) begin
                r_fpc   <= w_jump_tgt;
                r_rpc   <= w_jump_tgt;
                // Everything still in flight after this cycle belongs to the old path.
                r_drop  <= r_out - CW'(imem_rvalid);
                r_count <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
            end else begin
                if (w_grant)    r_fpc  <= r_fpc + 32'd4;
                if (w_push)     r_rpc  <= r_rpc + 32'd4;
                if (w_drop_rsp) r_drop <= r_drop - CW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                r_wptr  <= r_wptr + AW'(w_push);
                r_rptr  <= r_rptr + AW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wptr] <= r_rpc;
            r_mem_iw[r_wptr] <= imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iw_out      <= NOP;
            pc_out      <= RESET_PC;
            jump_en_out <= 1'b0;
        end else begin
            jump_en_out <= jump_en_in;
            if (jump_en_in) begin
                iw_out <= NOP;
            end else if (!stall_in) begin
                if (r_count != '0) begin
                    iw_out <= r_mem_iw[r_rptr];
                    pc_out <= r_mem_pc[r_rptr];
                end else begin
                    iw_out <= NOP;
                end
            end
        end
    end

`ifdef RV32I_IF_MISALIGN_CHK_EN
    logic r_misalign;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_misalign <= 1'b0;
        else if (jump_en_in && (jump_addr_in[1:0] != 2'b00))
            r_misalign <= 1'b1;
    end

    assign w_halted           = r_misalign;
    assign fetch_misalign_out = r_misalign;
`else
    logic w_unused_lsb;

    assign w_unused_lsb       = ^jump_addr_in[1:0];
    assign w_halted           = 1'b0;
    assign fetch_misalign_out = 1'b0;
`endif

endmodule

// File: doc/rv32i_if_fetch.md
# rv32i_if_fetch

Instruction-fetch stage of the RV32I pipeline. It owns the fetch PC, issues in-order requests to instruction memory through a request/grant/response handshake, and buffers returned words in a small FIFO. Each cycle it presents one instruction word and its PC to the decode stage. It consumes the decode stage's jump request (`jump_en`/`jump_addr`), flushes the wrong-path instructions, and returns the one-cycle "previous was a jump" indication that decode uses to suppress a second jump.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC after reset.
- `FIFO_DEPTH`, default 4: instruction buffer entries. Power of two, 2..8. This is also the maximum number of outstanding requests plus buffered words.
- `clk`, in, 1: system clock. All state is on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset. 0 = reset asserted.
- `jump_en_in`, in, 1: redirect request from decode.
- `jump_addr_in`, in, 32: redirect target from decode.
- `stall_in`, in, 1: downstream hold. While 1, `iw_out`/`pc_out` keep their values.
- `imem_req`, out, 1: fetch request valid. Combinational.
- `imem_addr`, out, 32: fetch address; equals the fetch PC.
- `imem_gnt`, in, 1: memory accepted the request this cycle. Only meaningful when `imem_req` = 1.
- `imem_rvalid`, in, 1: response valid. Responses return in order, at least 1 cycle after their grant.
- `imem_rdata`, in, 32: response instruction word.
- `iw_out`, out, 32: instruction word to decode. Registered.
- `pc_out`, out, 32: PC of `iw_out`. Registered.
- `jump_en_out`, out, 1: one-cycle pulse to decode's `jump_en_in`. Registered.
- `fetch_misalign_out`, out, 1: sticky misaligned-target flag. Registered. Tied 0 unless the configuration macro below is defined.

## Operation
- Internal state:
  - `fpc`: fetch PC.
  - `outstanding`: granted requests whose responses have not yet returned.
  - `drop`: responses still to be discarded.
  - FIFO of {pc, word}, with `count`.
- Request rule: `imem_req` = (`outstanding` + `count` < `FIFO_DEPTH`) && !`jump_en_in` && !halted. `imem_addr` = `fpc`.
- On a grant, `fpc` <= `fpc` + 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0) and `outstanding` increments.
- On `imem_rvalid`, `outstanding` decrements.
  - If `drop` > 0, the word is discarded and `drop` decrements.
  - Otherwise {pc, `imem_rdata`} is pushed, where pc is tracked by a response-PC counter. Pushing into a full FIFO is impossible by the credit rule; the bench flags it as an error.
- Output register, each edge with `stall_in` = 0:
  - FIFO non-empty: pop into `iw_out`/`pc_out`.
  - FIFO empty: `iw_out` <= 32'h13 (NOP bubble); `pc_out` holds.
- Redirect (`jump_en_in` = 1 at an edge):
  - `fpc` <= {`jump_addr_in`[31:2], 2'b00}.
  - FIFO cleared.
  - `drop` <= `outstanding` minus any response arriving in this same cycle. A response in the redirect cycle is discarded.
  - `iw_out` <= 32'h13.
  - `jump_en_out` <= 1 for exactly one cycle, otherwise 0.
  - Redirect overrides `stall_in`.
- Back-to-back redirects: each one restarts from the newest target. `drop` accumulates correctly.
- Reset while requests are outstanding: all counters clear. Memory must also be reset, so no stale responses arrive after reset release.
- Reset values:
  - `iw_out` = 32'h13, `pc_out` = `RESET_PC`, `jump_en_out` = 0, `fetch_misalign_out` = 0.
  - `fpc` = `RESET_PC`; FIFO and all counters = 0.
  - `imem_req` = 0 while reset is asserted.

## Timing
- With a 1-cycle memory: request granted in cycle C, `imem_rvalid` in C+1, FIFO write at the end of C+1, word on `iw_out` after the edge ending C+2. There is no FIFO bypass.
- Redirect sampled at edge N: `imem_req` with the target address in cycle N+1. The first target instruction appears on `iw_out` after the edge ending N+3 (1-cycle memory). NOP is held in between.
- Throughput: one instruction per cycle in steady state for `FIFO_DEPTH` >= 3 with a 1-cycle memory.

## Configuration
- `RV32I_IF_MISALIGN_CHK_EN` defined:
  - A redirect with `jump_addr_in`[1:0] != 0 sets `fetch_misalign_out` = 1 (sticky until reset).
  - It also halts fetching: `imem_req` is held at 0 and only NOPs are issued.
- Not defined: the low two bits are silently cleared and `fetch_misalign_out` is constant 0.

## Test plan
- Reset release, `RESET_PC` = 0, 1-cycle memory returning `addi` words → `iw_out` shows PCs 0, 4, 8 … on consecutive cycles after the initial fill bubbles; `jump_en_out` = 0.
- `jump_en_in` pulse with `jump_addr_in` = 32'h100 while 3 requests are outstanding → the 3 stale responses are dropped; `iw_out` = 32'h13 until the word at PC 32'h100; `jump_en_out` high for exactly 1 cycle.
- `stall_in` held for 5 cycles with memory streaming → `iw_out`/`pc_out` are frozen; `imem_req` drops once `outstanding` + `count` = 4; no overflow; order is resumed intact.
- Memory with 3-cycle latency and grants withheld randomly → in-order delivery; bubbles show 32'h13 with `pc_out` unchanged.
- `reset` asserted asynchronously mid-stream at PC 32'h40 → outputs return to reset values immediately; fetch restarts at `RESET_PC`.
- With `RV32I_IF_MISALIGN_CHK_EN`, redirect to 32'h102 → `fetch_misalign_out` = 1 and `imem_req` = 0 thereafter. Without the macro → fetch proceeds from 32'h100.
